// File: rtl/i2c_audio_slave.sv
// I2C write-only slave exposing a small bank of 9-bit audio codec registers.
// Bus frame: START, {DEV_ADDR,W}, {reg_addr,d8}, d[7:0], STOP.
module i2c_audio_slave #(
   parameter logic [6:0]  DEV_ADDR = 7'h1A,
   parameter int unsigned NUM_REGS = 10
) (
   input  logic       clk_i2c,
   input  logic       reset_n,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic [8:0] left_vol,
   output logic [8:0] right_vol,
   output logic       codec_active,
   output logic [3:0] write_count
);

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 9;
   localparam int unsigned CW = 4;
   localparam logic [AW-1:0] RESET_ALL_ADDR = 7'h0F;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_DATA, S_DATA_ACK, S_IGNORE
   } state_e;

   // Power-on / soft-reset value of each codec register.
   function automatic logic [DW-1:0] reg_default(input int unsigned idx);
      case (idx)
         0, 1:    reg_default = 9'h097;
         2, 3:    reg_default = 9'h079;
         4:       reg_default = 9'h00A;
         5:       reg_default = 9'h008;
         6:       reg_default = 9'h09F;
         7:       reg_default = 9'h00A;
         default: reg_default = 9'h000;
      endcase
   endfunction

   // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
   logic [2:0] scl_sync_q;
   logic [2:0] sda_sync_q;

   state_e           state_q,    state_d;
   logic [2:0]       bit_cnt_q,  bit_cnt_d;
   logic [6:0]       shift_q,    shift_d;
   logic             ack_on_q,   ack_on_d;
   logic [AW-1:0]    reg_addr_q, reg_addr_d;
   logic             d8_q,       d8_d;
   logic             sda_oe_q,   sda_oe_d;
   logic             wr_valid_q, wr_valid_d;
   logic [AW-1:0]    wr_addr_q,  wr_addr_d;
   logic [DW-1:0]    wr_data_q,  wr_data_d;
   logic [CW-1:0]    wr_cnt_q,   wr_cnt_d;
   logic [DW-1:0]    regs_q [NUM_REGS];

   logic          scl_s, scl_p, sda_s, sda_p;
   logic          scl_rise_c, scl_fall_c, start_c, stop_c;
   logic [7:0]    byte_c;
   logic          commit_c;
   logic [DW-1:0] wdata_c;

   // Two-flop synchronizers plus one history flop for edge detection.
   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl};
         sda_sync_q <= {sda_sync_q[1:0], sda_in};
      end
   end

   assign scl_s      = scl_sync_q[1];
   assign scl_p      = scl_sync_q[2];
   assign sda_s      = sda_sync_q[1];
   assign sda_p      = sda_sync_q[2];
   assign scl_rise_c = scl_s & ~scl_p;
   assign scl_fall_c = ~scl_s & scl_p;
   // SDA transitions only count as bus conditions while SCL is stably high.
   assign start_c    = scl_s & scl_p & sda_p & ~sda_s;
   assign stop_c     = scl_s & scl_p & ~sda_p & sda_s;
   assign byte_c     = {shift_q, sda_s};
   assign wdata_c    = {d8_q, byte_c};

   // State and control registers.
   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ack_on_q   <= 1'b0;
         reg_addr_q <= '0;
         d8_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ack_on_q   <= ack_on_d;
         reg_addr_q <= reg_addr_d;
         d8_q       <= d8_d;
         sda_oe_q   <= sda_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // Next-state logic: bus conditions override, then per-state byte handling.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ack_on_d   = ack_on_q;
      reg_addr_d = reg_addr_q;
      d8_d       = d8_q;
      sda_oe_d   = sda_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_cnt_d   = wr_cnt_q;
      commit_c   = 1'b0;

      if (start_c) begin
         state_d   = S_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         ack_on_d  = 1'b0;
      end else if (stop_c) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         ack_on_d  = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_REG, S_DATA: begin
               if (scl_rise_c) begin
                  shift_d   = byte_c[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     case (state_q)
                        S_ADDR: state_d = (byte_c == {DEV_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
                        S_REG: begin
                           reg_addr_d = byte_c[7:1];
                           d8_d       = byte_c[0];
                           state_d    = S_REG_ACK;
                        end
                        default: begin
                           commit_c   = 1'b1;
                           wr_valid_d = 1'b1;
                           wr_addr_d  = reg_addr_q;
                           wr_data_d  = wdata_c;
                           wr_cnt_d   = wr_cnt_q + 4'd1;
                           state_d    = S_DATA_ACK;
                        end
                     endcase
                  end
               end
            end
            S_ADDR_ACK, S_REG_ACK, S_DATA_ACK: begin
               // First SCL fall drives ACK, second releases it and moves on.
               if (scl_fall_c) begin
                  if (!ack_on_q) begin
                     ack_on_d = 1'b1;
                     sda_oe_d = 1'b1;
                  end else begin
                     ack_on_d = 1'b0;
                     sda_oe_d = 1'b0;
                     case (state_q)
                        S_ADDR_ACK: state_d = S_REG;
                        S_REG_ACK:  state_d = S_DATA;
                        default:    state_d = S_IGNORE;
                     endcase
                  end
               end
            end
            S_IGNORE: sda_oe_d = 1'b0;
            default:  state_d  = S_IDLE;
         endcase
      end
   end

   // Register bank: single-register write or soft reset of every register.
   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
      end else if (commit_c) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (reg_addr_q == RESET_ALL_ADDR)  regs_q[i] <= reg_default(i);
            else if (reg_addr_q == AW'(i))     regs_q[i] <= wdata_c;
         end
      end
   end

   assign sda_oe       = sda_oe_q;
   assign wr_valid     = wr_valid_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign write_count  = wr_cnt_q;
   assign left_vol     = regs_q[2];
   assign right_vol    = regs_q[3];
   assign codec_active = regs_q[9][0];

endmodule
